// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the fetch/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2
    } arb_state_t;

    localparam logic [2:0] WIDTH_WORD   = 3'b010;
    localparam int         STARVE_CNT_W = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Registered data-priority arbiter sharing one memory bus between
//               the fetch and data ports, with fetch starvation guard and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        flush_if_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,

    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic [2:0]  dm_width_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ready_o,

    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [2:0]  bus_width_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    import mem_arb_pkg::*;

    localparam logic [STARVE_CNT_W-1:0] c_starve_limit = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic                    r_drop;
    logic [STARVE_CNT_W-1:0] r_starve_cnt;

    logic w_if_elig;
    logic w_dm_elig;
    logic w_starved;
    logic w_grant_if;
    logic w_grant_dm;
    logic w_if_done;
    logic w_if_deliver;
    logic w_dm_done;

    // State register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_if) begin
                    w_state_nxt = GNT_IF;
                end else if (w_grant_dm) begin
                    w_state_nxt = GNT_DM;
                end
            end
            GNT_IF, GNT_DM: begin
                if (bus_ack_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant and completion decode; a port is masked during its own ready cycle
    always_comb begin
        w_if_elig    = if_req_i && !if_ready_o && !flush_if_i;
        w_dm_elig    = dm_req_i && !dm_ready_o;
        w_starved    = (r_starve_cnt == c_starve_limit);
        w_grant_if   = (r_state == IDLE) && w_if_elig && (!w_dm_elig || w_starved);
        w_grant_dm   = (r_state == IDLE) && w_dm_elig && !w_grant_if;
        w_if_done    = (r_state == GNT_IF) && bus_ack_i;
        w_if_deliver = w_if_done && !r_drop && !flush_if_i;
        w_dm_done    = (r_state == GNT_DM) && bus_ack_i;
    end

    // Bus attribute registers and response registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'd0;
            bus_wdata_o <= 32'd0;
            bus_width_o <= 3'd0;
            if_rdata_o  <= 32'd0;
            if_ready_o  <= 1'b0;
            dm_rdata_o  <= 32'd0;
            dm_ready_o  <= 1'b0;
        end else begin
            if_ready_o <= w_if_deliver;
            dm_ready_o <= w_dm_done;

            if (w_grant_if) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= 1'b0;
                bus_addr_o  <= if_addr_i;
                bus_wdata_o <= 32'd0;
                bus_width_o <= WIDTH_WORD;
            end else if (w_grant_dm) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= dm_we_i;
                bus_addr_o  <= dm_addr_i;
                bus_wdata_o <= dm_wdata_i;
                bus_width_o <= dm_width_i;
            end else if (w_if_done || w_dm_done) begin
                bus_req_o   <= 1'b0;
            end

            if (w_if_deliver) begin
                if_rdata_o <= bus_rdata_i;
            end
            if (w_dm_done) begin
                dm_rdata_o <= bus_rdata_i;
            end
        end
    end

    // Flush bookkeeping: a cancelled fetch still owns the bus until its ack
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_drop <= 1'b0;
        end else if (w_if_done) begin
            r_drop <= 1'b0;
        end else if ((r_state == GNT_IF) && flush_if_i) begin
            r_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_starve_cnt <= '0;
        end else if (w_grant_if || ((w_grant_dm) && !if_req_i)) begin
            r_starve_cnt <= '0;
        end else if (w_grant_dm && (r_starve_cnt != c_starve_limit)) begin
            r_starve_cnt <= r_starve_cnt + STARVE_CNT_W'(1);
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        flush_if_i;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [2:0]  dm_width_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ready_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [2:0]  bus_width_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    int n_pass  = 0;
    int n_total = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .flush_if_i  (flush_if_i),
        .if_rdata_o  (if_rdata_o),
        .if_ready_o  (if_ready_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_width_i  (dm_width_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ready_o  (dm_ready_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_width_o (bus_width_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_req"},  {31'd0, bus_req_o},   32'd0);
        check({tag, "_bus_we"},   {31'd0, bus_we_o},    32'd0);
        check({tag, "_bus_addr"}, bus_addr_o,           32'd0);
        check({tag, "_bus_wd"},   bus_wdata_o,          32'd0);
        check({tag, "_bus_wid"},  {29'd0, bus_width_o}, 32'd0);
        check({tag, "_if_rdy"},   {31'd0, if_ready_o},  32'd0);
        check({tag, "_if_rd"},    if_rdata_o,           32'd0);
        check({tag, "_dm_rdy"},   {31'd0, dm_ready_o},  32'd0);
        check({tag, "_dm_rd"},    dm_rdata_o,           32'd0);
    endtask

    initial begin
        reset_i     = 1'b0;
        if_req_i    = 1'b0;
        if_addr_i   = 32'd0;
        flush_if_i  = 1'b0;
        dm_req_i    = 1'b0;
        dm_we_i     = 1'b0;
        dm_addr_i   = 32'd0;
        dm_wdata_i  = 32'd0;
        dm_width_i  = 3'd0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'd0;

        tick();
        tick();
        check_all_zero("reset");
        reset_i = 1'b1;
        tick();

        // Fetch only, zero-wait
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0100;
        tick();
        check("f1_bus_req",  {31'd0, bus_req_o},   32'd1);
        check("f1_bus_addr", bus_addr_o,           32'h0000_0100);
        check("f1_bus_we",   {31'd0, bus_we_o},    32'd0);
        check("f1_bus_wid",  {29'd0, bus_width_o}, 32'd2);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h0050_0093;
        tick();
        check("f1_if_rdy",   {31'd0, if_ready_o},  32'd1);
        check("f1_if_rdata", if_rdata_o,           32'h0050_0093);
        check("f1_bus_drop", {31'd0, bus_req_o},   32'd0);
        bus_ack_i = 1'b0;
        if_req_i  = 1'b0;
        tick();
        check("f1_if_pulse", {31'd0, if_ready_o},  32'd0);

        // Simultaneous fetch and store: store first
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0104;
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b1;
        dm_addr_i  = 32'h0000_2000;
        dm_wdata_i = 32'hDEAD_BEEF;
        dm_width_i = 3'b010;
        tick();
        check("s_dm_addr",  bus_addr_o,         32'h0000_2000);
        check("s_dm_we",    {31'd0, bus_we_o},  32'd1);
        check("s_dm_wdata", bus_wdata_o,        32'hDEAD_BEEF);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h0;
        tick();
        check("s_dm_rdy",   {31'd0, dm_ready_o}, 32'd1);
        bus_ack_i = 1'b0;
        dm_req_i  = 1'b0;
        dm_we_i   = 1'b0;
        tick();
        check("s_if_addr",  bus_addr_o,          32'h0000_0104);
        check("s_if_we",    {31'd0, bus_we_o},   32'd0);
        check("s_if_wdata", bus_wdata_o,         32'd0);
        check("s_starve0",  {28'd0, dut.r_starve_cnt}, 32'd0);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h1111_1111;
        tick();
        check("s_if_rdy",   {31'd0, if_ready_o}, 32'd1);
        bus_ack_i = 1'b0;
        if_req_i  = 1'b0;
        tick();

        // Starvation: fetch masked by flush only during each data ready cycle
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0108;
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b0;
        dm_addr_i  = 32'h0000_4000;
        dm_width_i = 3'b010;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("st_dm_grant%0d", k), bus_addr_o, 32'h0000_4000);
            check($sformatf("st_cnt%0d", k), {28'd0, dut.r_starve_cnt}, k);
            bus_ack_i   = 1'b1;
            bus_rdata_i = 32'hA000_0000 + k;
            tick();
            bus_ack_i  = 1'b0;
            flush_if_i = 1'b1;
            check($sformatf("st_dm_rdy%0d", k), {31'd0, dm_ready_o}, 32'd1);
            tick();
            flush_if_i = 1'b0;
        end
        tick();
        check("st_if_grant", bus_addr_o,               32'h0000_0108);
        check("st_if_we",    {31'd0, bus_we_o},        32'd0);
        check("st_cnt_clr",  {28'd0, dut.r_starve_cnt}, 32'd0);
        check("st_dm_rdata", dm_rdata_o,               32'hA000_0004);
        dm_req_i    = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h2222_2222;
        tick();
        check("st_if_rdy",   {31'd0, if_ready_o},      32'd1);
        bus_ack_i = 1'b0;
        if_req_i  = 1'b0;
        tick();

        // Flush mid-fetch, ack after 3 wait cycles, then refetch
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_010C;
        tick();
        check("fl_grant",    bus_addr_o,          32'h0000_010C);
        flush_if_i = 1'b1;
        tick();
        flush_if_i = 1'b0;
        if_addr_i  = 32'h0000_0200;
        tick();
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h0000_0BAD;
        tick();
        check("fl_no_rdy",   {31'd0, if_ready_o}, 32'd0);
        check("fl_rdata",    if_rdata_o,          32'h2222_2222);
        check("fl_bus_drop", {31'd0, bus_req_o},  32'd0);
        bus_ack_i = 1'b0;
        tick();
        check("fl_refetch",  bus_addr_o,          32'h0000_0200);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h0000_0013;
        tick();
        check("fl_re_rdy",   {31'd0, if_ready_o}, 32'd1);
        check("fl_re_rdata", if_rdata_o,          32'h0000_0013);
        bus_ack_i = 1'b0;
        if_req_i  = 1'b0;
        tick();

        // Byte load with 5 wait cycles
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b0;
        dm_addr_i  = 32'h0000_3000;
        dm_width_i = 3'b000;
        tick();
        for (int w = 1; w <= 5; w++) begin
            check($sformatf("ld_req%0d", w), {31'd0, bus_req_o},   32'd1);
            check($sformatf("ld_wid%0d", w), {29'd0, bus_width_o}, 32'd0);
            check($sformatf("ld_adr%0d", w), bus_addr_o,           32'h0000_3000);
            check($sformatf("ld_rdy%0d", w), {31'd0, dm_ready_o},  32'd0);
            if (w == 5) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = 32'h0000_00AB;
            end
            tick();
        end
        check("ld_rdy",      {31'd0, dm_ready_o}, 32'd1);
        check("ld_rdata",    dm_rdata_o,          32'h0000_00AB);
        dm_req_i    = 1'b0;
        bus_rdata_i = 32'h5555_5555;
        tick();
        // Stray ack in IDLE
        check("stray_dm",    {31'd0, dm_ready_o}, 32'd0);
        check("stray_if",    {31'd0, if_ready_o}, 32'd0);
        check("stray_breq",  {31'd0, bus_req_o},  32'd0);
        check("ld_hold",     dm_rdata_o,          32'h0000_00AB);
        bus_ack_i = 1'b0;
        tick();

        // Asynchronous reset during a data store
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b1;
        dm_addr_i  = 32'h0000_5000;
        dm_wdata_i = 32'h1234_5678;
        dm_width_i = 3'b010;
        tick();
        check("rs_granted",  {31'd0, bus_req_o},  32'd1);
        #2;
        reset_i  = 1'b0;
        dm_req_i = 1'b0;
        #1;
        check_all_zero("rs_async");
        tick();
        reset_i = 1'b1;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h7777_7777;
        tick();
        check("rs_late_ack", {31'd0, dm_ready_o}, 32'd0);
        check("rs_late_req", {31'd0, bus_req_o},  32'd0);
        bus_ack_i = 1'b0;
        tick();
        check("rs_late_rd",  dm_rdata_o,          32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single unified memory bus between the fetch-stage instruction port and the memory-stage data port of the pipelined core. Arbitration is registered and data-priority with a starvation guard for fetch. Fetch accesses can be cancelled by a branch flush. Requesters stall on `*_req_i && !*_ready_o`; the hazard unit consumes the same signals.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch is pending before fetch is forced (1..15).
- `clk_i` in 1: clock.
- `reset_i` in 1: asynchronous, active-low reset.
- `if_req_i` in 1: fetch request; held until `if_ready_o`.
- `if_addr_i` in 32: fetch address.
- `flush_if_i` in 1: cancel the outstanding or pending fetch.
- `if_rdata_o` out 32: fetched instruction, valid with `if_ready_o`.
- `if_ready_o` out 1: one-cycle fetch completion pulse.
- `dm_req_i` in 1: data request; held until `dm_ready_o`.
- `dm_we_i` in 1: data write.
- `dm_addr_i` in 32: data address.
- `dm_wdata_i` in 32: store data.
- `dm_width_i` in 3: width encoding, same as `width_src`.
- `dm_rdata_o` out 32: load data, valid with `dm_ready_o`.
- `dm_ready_o` out 1: one-cycle data completion pulse. Also pulses for stores.
- `bus_req_o` out 1: bus request, held until ack.
- `bus_we_o`, `bus_addr_o` [32], `bus_wdata_o` [32], `bus_width_o` [3]: out; latched access attributes.
- `bus_ack_i` in 1: bus completion. `bus_rdata_i` is valid in the same cycle.
- `bus_rdata_i` in 32: bus read data.

## Operation
- States:
  - `IDLE`: no bus access outstanding.
  - `GNT_IF`: fetch access on the bus.
  - `GNT_DM`: data access on the bus.
- Arbitration in `IDLE`:
  - Eligible request = `req && !ready_o` for that port in the current cycle. This masks the completing port.
  - If both ports are eligible, data wins unless `starve_cnt == STARVE_LIMIT`; then fetch wins.
  - A fetch is not eligible while `flush_if_i` is high.
- On grant:
  - Latch address, write data, width and `we` into the bus registers.
  - For fetch: `bus_we_o` = 0, `bus_width_o` = 3'b010 (word), `bus_wdata_o` = 0.
- `starve_cnt` (4-bit):
  - Increments on a data grant while `if_req_i` is high.
  - Clears on a fetch grant, or when `if_req_i` is low at a grant.
  - Saturates at `STARVE_LIMIT`.
- In `GNT_x`, when `bus_ack_i` is sampled high:
  - Register `bus_rdata_i` into `x_rdata_o`.
  - Pulse `x_ready_o` next cycle.
  - Drop `bus_req_o` and return to `IDLE`.
- Flush:
  - `flush_if_i` in `GNT_IF` sets `drop`.
  - On ack with `drop` set (or `flush_if_i` high in the ack cycle): no `if_ready_o`, `if_rdata_o` is unchanged, `drop` clears.
  - `flush_if_i` coincident with an already-registered `if_ready_o`: the pulse still occurs; the requester discards it.
  - Data accesses are never cancelled.
- `bus_ack_i` in `IDLE` is ignored (stray ack).
- Reset (asynchronous, any state):
  - State → `IDLE`; `drop` and `starve_cnt` → 0.
  - All outputs → 0 immediately, including mid-transaction `bus_req_o`.
  - An ack for the aborted access is ignored.

## Timing
- Request sampled in `IDLE` at edge N → `bus_req_o` high in cycle N+1.
- With zero-wait ack in N+1, `x_ready_o` is high in N+2.
- Minimum latency: 2 cycles. Each bus wait state adds 1.
- Back-to-back accesses: the next grant can occur at the edge ending the ready cycle, so minimum spacing is 2 cycles per access.
- `x_rdata_o` holds its value until the next completion on that port.
- `x_ready_o` is high for exactly one cycle per completed, non-dropped access.
- `bus_*` attributes are stable from grant through the ack cycle.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum {`IDLE`, `GNT_IF`, `GNT_DM`}.
  - `WIDTH_WORD` = 3'b010.
  - Starvation counter width constant.
- Single flat module. The grant decision is a small combinational block inside it; no sub-module.

## Test plan
- Fetch only:
  - Stimulus: `if_req_i` = 1, `if_addr_i` = 0x100, zero-wait ack with `bus_rdata_i` = 0x00500093.
  - Response: `bus_req_o` in cycle 1 with `bus_addr_o` = 0x100, `bus_we_o` = 0; `if_ready_o` in cycle 2 with `if_rdata_o` = 0x00500093.
- Simultaneous requests:
  - Stimulus: fetch 0x104 and data store (0x2000, 0xDEADBEEF, width 3'b010) requested together.
  - Response: store granted first with `bus_we_o` = 1 and `bus_wdata_o` = 0xDEADBEEF; fetch granted after `dm_ready_o`.
- Starvation:
  - Stimulus: `if_req_i` held; `dm_req_i` re-asserted continuously with `STARVE_LIMIT` = 4.
  - Response: exactly 4 data grants, then a fetch grant, then `starve_cnt` = 0.
- Flush mid-fetch:
  - Stimulus: `GNT_IF` with ack delayed 3 cycles; `flush_if_i` pulsed in wait cycle 1.
  - Response: no `if_ready_o`, `if_rdata_o` unchanged, return to `IDLE`; a new fetch to 0x200 completes normally.
- Wait states on load:
  - Stimulus: load 0x3000, width 3'b000, ack after 5 cycles with data 0x000000AB.
  - Response: `bus_req_o` and `bus_width_o` = 3'b000 stable for 5 cycles; `dm_ready_o` with `dm_rdata_o` = 0x000000AB.
- Reset mid-transaction:
  - Stimulus: `reset_i` low during `GNT_DM`, then ack arrives after release.
  - Response: all outputs 0 asynchronously; the late ack is ignored (no `dm_ready_o`).
